// File: rtl/fcu_pkg.sv
// Shared definitions for the flag computation unit: condition encodings, CC bit indices and
// the overflow derivation used by both the ALU-side and branch-side logic.
package fcu_pkg;

  localparam logic [3:0] COND_EQ  = 4'h0;
  localparam logic [3:0] COND_NE  = 4'h1;
  localparam logic [3:0] COND_LT  = 4'h2;
  localparam logic [3:0] COND_GE  = 4'h3;
  localparam logic [3:0] COND_LE  = 4'h4;
  localparam logic [3:0] COND_GT  = 4'h5;
  localparam logic [3:0] COND_LTU = 4'h6;
  localparam logic [3:0] COND_GEU = 4'h7;
  localparam logic [3:0] COND_LEU = 4'h8;
  localparam logic [3:0] COND_GTU = 4'h9;
  localparam logic [3:0] COND_VS  = 4'hA;
  localparam logic [3:0] COND_VC  = 4'hB;
  localparam logic [3:0] COND_MI  = 4'hC;
  localparam logic [3:0] COND_PL  = 4'hD;
  localparam logic [3:0] COND_AL  = 4'hE;
  localparam logic [3:0] COND_NV  = 4'hF;

  localparam int unsigned CC_Z = 3;
  localparam int unsigned CC_N = 2;
  localparam int unsigned CC_C = 1;
  localparam int unsigned CC_V = 0;

  // b_msb is the operand as supplied, before the ALU inverts it for subtraction
  function automatic logic live_v(input logic is_sub, input logic a_msb, input logic b_msb,
                                  input logic r_msb);
    if (is_sub) return (a_msb != b_msb) && (r_msb != a_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/fcu_cond_eval.sv
// Combinational evaluation of a 4-bit branch condition against a {Z,N,C,V} flag set.
module fcu_cond_eval
  import fcu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_verdict
);

  logic w_z, w_n, w_c, w_v, w_lt;

  assign w_z  = i_flags[CC_Z];
  assign w_n  = i_flags[CC_N];
  assign w_c  = i_flags[CC_C];
  assign w_v  = i_flags[CC_V];
  assign w_lt = w_n ^ w_v;

  always_comb begin
    o_verdict = 1'b0;
    unique case (i_cond)
      COND_EQ:  o_verdict = w_z;
      COND_NE:  o_verdict = !w_z;
      COND_LT:  o_verdict = w_lt;
      COND_GE:  o_verdict = !w_lt;
      COND_LE:  o_verdict = w_z | w_lt;
      COND_GT:  o_verdict = !w_z & !w_lt;
      COND_LTU: o_verdict = !w_c;
      COND_GEU: o_verdict = w_c;
      COND_LEU: o_verdict = !w_c | w_z;
      COND_GTU: o_verdict = w_c & !w_z;
      COND_VS:  o_verdict = w_v;
      COND_VC:  o_verdict = !w_v;
      COND_MI:  o_verdict = w_n;
      COND_PL:  o_verdict = !w_n;
      COND_AL:  o_verdict = 1'b1;
      COND_NV:  o_verdict = 1'b0;
      default:  o_verdict = 1'b0;
    endcase
  end

endmodule

// File: rtl/fcu_cc_unit.sv
// Flag derivation, NCTX condition-code contexts, condition evaluation and a single-entry
// valid/ready output register holding the verdict and the flags it was computed from.
module fcu_cc_unit
  import fcu_pkg::*;
#(
  parameter int         WIDTH  = 16,
  parameter int         NCTX   = 1,
  parameter logic [3:0] CC_RST = 4'b0000,
  localparam int        CTXW   = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] res,
  input  logic             carry,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             is_sub,
  input  logic [3:0]       cond,
  input  logic             use_cc,
  input  logic             cc_we,
  input  logic [CTXW-1:0]  ctx,
  input  logic             sticky_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_flag,
  output logic [3:0]       out_cc,
  output logic             sticky_v
);

  logic [3:0] r_cc [NCTX];
  logic       r_out_valid;
  logic       r_out_flag;
  logic [3:0] r_out_cc;
  logic       r_sticky;

  logic [3:0] w_live;
  logic [3:0] w_cc_sel;
  logic [3:0] w_flags;
  logic       w_ctx_ok;
  logic       w_accept;
  logic       w_verdict;

  assign w_live[CC_Z] = ~|res;
  assign w_live[CC_N] = res[WIDTH-1];
  assign w_live[CC_C] = carry;
  assign w_live[CC_V] = live_v(is_sub, a_msb, b_msb, res[WIDTH-1]);

  // Out-of-range contexts read as the reset value and never take writes
  always_comb begin
    w_ctx_ok = 1'b0;
    w_cc_sel = CC_RST;
    for (int i = 0; i < NCTX; i++) begin
      if (ctx == CTXW'(i)) begin
        w_ctx_ok = 1'b1;
        w_cc_sel = r_cc[i];
      end
    end
  end

  assign w_flags  = use_cc ? w_cc_sel : w_live;
  assign in_ready = !r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  fcu_cond_eval u_cond_eval (
    .i_cond    (cond),
    .i_flags   (w_flags),
    .o_verdict (w_verdict)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_flag  <= 1'b0;
      r_out_cc    <= 4'b0000;
      r_sticky    <= 1'b0;
      for (int i = 0; i < NCTX; i++) r_cc[i] <= CC_RST;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_flag  <= w_verdict;
        r_out_cc    <= w_flags;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      for (int i = 0; i < NCTX; i++) begin
        if (w_accept && cc_we && (ctx == CTXW'(i))) r_cc[i] <= w_live;
      end
      if (w_accept && cc_we && w_ctx_ok && w_live[CC_V]) r_sticky <= 1'b1;
      else if (sticky_clr)                             r_sticky <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_flag  = r_out_flag;
  assign out_cc    = r_out_cc;
  assign sticky_v  = r_sticky;

endmodule

// File: tb/tb_fcu_cc_unit.sv
// Self-checking bench for fcu_cc_unit: directed vector table, handshake/sticky/reset sequences
// and randomized ALU traffic checked against an arithmetic reference model.
module tb_fcu_cc_unit;

  localparam int         WIDTH  = 16;
  localparam int         NCTX   = 3;
  localparam logic [3:0] CC_RST = 4'b0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] res = '0;
  logic        carry = 1'b0;
  logic        a_msb = 1'b0;
  logic        b_msb = 1'b0;
  logic        is_sub = 1'b0;
  logic [3:0]  cond = '0;
  logic        use_cc = 1'b0;
  logic        cc_we = 1'b0;
  logic [1:0]  ctx = '0;
  logic        sticky_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_flag;
  logic [3:0]  out_cc;
  logic        sticky_v;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fcu_cc_unit #(.WIDTH(WIDTH), .NCTX(NCTX), .CC_RST(CC_RST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .res(res),
    .carry(carry), .a_msb(a_msb), .b_msb(b_msb), .is_sub(is_sub), .cond(cond),
    .use_cc(use_cc), .cc_we(cc_we), .ctx(ctx), .sticky_clr(sticky_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_flag(out_flag), .out_cc(out_cc),
    .sticky_v(sticky_v)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] r, input logic c, input logic am, input logic bm,
                       input logic sub, input logic [3:0] cd, input logic uc, input logic we,
                       input logic [1:0] cx);
    res = r; carry = c; a_msb = am; b_msb = bm; is_sub = sub;
    cond = cd; use_cc = uc; cc_we = we; ctx = cx;
  endtask

  // Condition table written directly from the condition definitions
  function automatic logic m_verdict(input logic [3:0] cd, input logic [3:0] f);
    logic z, n, c, v;
    {z, n, c, v} = f;
    case (cd)
      4'h0: return z;           4'h1: return !z;
      4'h2: return n != v;      4'h3: return n == v;
      4'h4: return z || (n != v); 4'h5: return !z && (n == v);
      4'h6: return !c;          4'h7: return c;
      4'h8: return !c || z;     4'h9: return c && !z;
      4'hA: return v;           4'hB: return !v;
      4'hC: return n;           4'hD: return !n;
      4'hE: return 1'b1;        default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [15:0] r; logic c; logic am; logic bm; logic sub;
    logic [3:0] cd; logic uc; logic we; logic [1:0] cx;
    logic ef; logic [3:0] ecc; logic es;
  } vec_t;

  vec_t tbl[16];

  // Reference model state
  logic [3:0] m_cc [4];
  logic       m_valid, m_flag, m_sticky;
  logic [3:0] m_occ;

  initial begin
    tbl[0]  = '{16'h0000, 0, 0, 0, 1, 4'h0, 0, 0, 2'd0, 1, 4'b1000, 0};
    tbl[1]  = '{16'h7FFF, 1, 1, 0, 1, 4'h2, 0, 0, 2'd0, 1, 4'b0011, 0};
    tbl[2]  = '{16'h7FFF, 1, 1, 0, 1, 4'h7, 0, 0, 2'd0, 1, 4'b0011, 0};
    tbl[3]  = '{16'h7FFF, 1, 1, 0, 1, 4'h5, 0, 0, 2'd0, 0, 4'b0011, 0};
    tbl[4]  = '{16'h8000, 0, 0, 0, 0, 4'hA, 0, 1, 2'd0, 1, 4'b0101, 1};
    tbl[5]  = '{16'h0001, 1, 0, 0, 0, 4'hC, 1, 0, 2'd0, 1, 4'b0101, 1};
    tbl[6]  = '{16'h0001, 1, 0, 0, 0, 4'h0, 1, 0, 2'd1, 0, 4'b0010, 1};
    tbl[7]  = '{16'h0001, 1, 0, 0, 0, 4'h7, 1, 0, 2'd3, 1, 4'b0010, 1};
    tbl[8]  = '{16'h0000, 0, 0, 0, 0, 4'hE, 0, 1, 2'd3, 1, 4'b1000, 1};
    tbl[9]  = '{16'h0000, 0, 0, 0, 0, 4'h0, 1, 0, 2'd3, 0, 4'b0010, 1};
    tbl[10] = '{16'h0000, 0, 0, 0, 0, 4'h1, 1, 0, 2'd0, 1, 4'b0101, 1};
    tbl[11] = '{16'hFFFF, 1, 1, 1, 1, 4'hF, 0, 0, 2'd0, 0, 4'b0110, 1};
    tbl[12] = '{16'hFFFF, 1, 1, 1, 1, 4'hD, 0, 0, 2'd0, 0, 4'b0110, 1};
    tbl[13] = '{16'hFFFF, 1, 1, 1, 1, 4'h8, 0, 0, 2'd0, 0, 4'b0110, 1};
    tbl[14] = '{16'hFFFF, 1, 1, 1, 1, 4'h9, 0, 0, 2'd0, 1, 4'b0110, 1};
    tbl[15] = '{16'hFFFF, 1, 1, 1, 1, 4'hB, 0, 0, 2'd0, 1, 4'b0110, 1};

    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sticky", sticky_v, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table, one accept per cycle
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].am, tbl[i].bm, tbl[i].sub, tbl[i].cd, tbl[i].uc,
            tbl[i].we, tbl[i].cx);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_flag", i), out_flag, tbl[i].ef);
      chk($sformatf("tbl%0d_cc", i), out_cc, tbl[i].ecc);
      chk($sformatf("tbl%0d_sticky", i), sticky_v, tbl[i].es);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", out_valid, 0);
    chk("drain_flag_hold", out_flag, 1);

    // Stall: pending verdict holds, new request and its CC write are not taken
    rst_n = 1'b0; #1; rst_n = 1'b1;
    drive(16'h0000, 0, 0, 0, 0, 4'h0, 0, 0, 2'd0); in_valid = 1'b1;
    @(negedge clk);
    drive(16'h0001, 0, 0, 0, 0, 4'h0, 0, 1, 2'd0); out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_flag", out_flag, 1);
      chk("stall_cc", out_cc, 4'b1000);
      @(negedge clk);
    end
    drive(16'h0001, 0, 0, 0, 0, 4'h0, 1, 0, 2'd0); out_ready = 1'b1;
    @(negedge clk);
    chk("resume_valid", out_valid, 1);
    chk("resume_flag", out_flag, 0);
    chk("resume_cc_unchanged", out_cc, CC_RST);
    in_valid = 1'b0;
    @(negedge clk);
    chk("resume_drain", out_valid, 0);

    // Sticky overflow: set wins over a same-cycle clear, lone clear drops it
    drive(16'h8000, 0, 0, 0, 0, 4'hE, 0, 1, 2'd0); in_valid = 1'b1;
    @(negedge clk);
    chk("sticky_set", sticky_v, 1);
    sticky_clr = 1'b1;
    @(negedge clk);
    chk("sticky_set_wins", sticky_v, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sticky_clear", sticky_v, 0);
    sticky_clr = 1'b0;

    // Asynchronous reset in the middle of a stall
    drive(16'h8000, 0, 0, 0, 0, 4'hE, 0, 1, 2'd1); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_sticky", sticky_v, 1);
    #2; rst_n = 1'b0; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_sticky", sticky_v, 0);
    chk("arst_flag", out_flag, 0);
    chk("arst_cc", out_cc, 0);
    chk("arst_in_ready", in_ready, 1);
    drive(16'h0000, 0, 0, 0, 0, 4'h0, 1, 0, 2'd1); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cc1", out_cc, CC_RST);
    chk("post_rst_flag", out_flag, 0);

    // Randomized traffic against the arithmetic model
    in_valid = 1'b0;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_cc[i] = CC_RST;
    m_valid = 0; m_flag = 0; m_occ = 0; m_sticky = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [15:0] a, b;
      logic [16:0] sum;
      int ia, ib, ir;
      logic sub, vflag, acc, ok;
      logic [3:0] live, used;
      @(negedge clk);
      chk("rnd_valid", out_valid, m_valid);
      chk("rnd_flag", out_flag, m_flag);
      chk("rnd_cc", out_cc, m_occ);
      chk("rnd_sticky", sticky_v, m_sticky);
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = sub ? a : 16'(-a);
      if ($urandom_range(0, 5) == 0) begin a[14:0] = 15'h7FFF; b[14:0] = 15'h0001; end
      sum = sub ? {1'b0, a} + {1'b0, ~b} + 17'd1 : {1'b0, a} + {1'b0, b};
      ia = a[15] ? int'(a) - 65536 : int'(a);
      ib = b[15] ? int'(b) - 65536 : int'(b);
      ir = sub ? ia - ib : ia + ib;
      vflag = (ir > 32767) || (ir < -32768);
      live = {sum[15:0] == 16'h0, sum[15], sum[16], vflag};
      drive(sum[15:0], sum[16], a[15], b[15], sub, 4'($urandom), 1'($urandom),
            1'($urandom), 2'($urandom));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sticky_clr = ($urandom_range(0, 7) == 0);
      #1;
      chk("rnd_in_ready", in_ready, !m_valid || out_ready);
      acc = in_valid && (!m_valid || out_ready);
      ok = (int'(ctx) < NCTX);
      used = use_cc ? (ok ? m_cc[ctx] : CC_RST) : live;
      if (acc) begin
        m_valid = 1; m_flag = m_verdict(cond, used); m_occ = used;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (acc && cc_we && ok && vflag) m_sticky = 1;
      else if (sticky_clr) m_sticky = 0;
      if (acc && cc_we && ok) m_cc[ctx] = live;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
